// File: rtl/sub_instance_sequencer_if.sv
// rtl/sub_instance_sequencer_if.sv - control/status bundle between a run requester and the child sequencer
interface sub_instance_sequencer_if #(
  parameter int NUM_CHILD = 5,
  parameter int TMO_W     = 8
);
  localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

  logic                 start_i;
  logic [NUM_CHILD-1:0] enable_mask_i;
  logic [TMO_W-1:0]     timeout_i;
  logic [NUM_CHILD-1:0] child_done_i;
  logic [NUM_CHILD-1:0] child_start_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 error_o;
  logic [IDX_W-1:0]     err_idx_o;
  logic [IDX_W-1:0]     cur_idx_o;

  modport master (
    output start_i, enable_mask_i, timeout_i, child_done_i,
    input  child_start_o, busy_o, done_o, error_o, err_idx_o, cur_idx_o
  );

  modport slave (
    input  start_i, enable_mask_i, timeout_i, child_done_i,
    output child_start_o, busy_o, done_o, error_o, err_idx_o, cur_idx_o
  );
endinterface

// File: rtl/sub_instance_sequencer.sv
// rtl/sub_instance_sequencer.sv - starts enabled children one at a time, waiting on each with an optional timeout
module sub_instance_sequencer #(
  parameter int NUM_CHILD = 5,
  parameter int TMO_W     = 8
) (
  input logic                     clk,
  input logic                     rst,
  sub_instance_sequencer_if.slave bus
);
  localparam int IDX_W = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t               r_state;
  logic [NUM_CHILD-1:0] r_mask;
  logic [TMO_W-1:0]     r_tmo;
  logic [TMO_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_err_idx;
  logic                 r_err_flag;
  logic [NUM_CHILD-1:0] r_child_start;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  // Pulse outputs default low each cycle and are raised on the transition into their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mask        <= '0;
      r_tmo         <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_err_idx     <= '0;
      r_err_flag    <= 1'b0;
      r_child_start <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_child_start <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_mask    <= bus.enable_mask_i;
            r_tmo     <= bus.timeout_i;
            r_idx     <= '0;
            r_err_idx <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_mask[r_idx]) begin
            r_child_start <= NUM_CHILD'(1) << r_idx;
            r_state       <= ST_LAUNCH;
          end else if (r_idx == LAST_IDX) begin
            r_done  <= 1'b1;
            r_error <= r_err_flag;
            r_state <= ST_FINISH;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion is checked first so a done on the timeout cycle still counts as success.
          if (bus.child_done_i[r_idx]) begin
            if (r_idx == LAST_IDX) begin
              r_done  <= 1'b1;
              r_error <= r_err_flag;
              r_state <= ST_FINISH;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_SCAN;
            end
          end else if ((r_tmo != '0) && (r_cnt == r_tmo)) begin
            r_err_flag <= 1'b1;
            r_err_idx  <= r_idx;
            r_done     <= 1'b1;
            r_error    <= 1'b1;
            r_state    <= ST_FINISH;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          r_err_flag <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.child_start_o = r_child_start;
  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.error_o       = r_error;
  assign bus.err_idx_o     = r_err_idx;
  assign bus.cur_idx_o     = r_idx;
endmodule

// File: tb/tb_sub_instance_sequencer.sv
// tb/tb_sub_instance_sequencer.sv - directed self-checking bench for sub_instance_sequencer
module tb_sub_instance_sequencer;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  sub_instance_sequencer_if #(.NUM_CHILD(5), .TMO_W(8)) bus ();

  sub_instance_sequencer #(.NUM_CHILD(5), .TMO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bench answers each launch with that child's done in the following cycle.
  task automatic run_respond(input string tag, input logic [4:0] mask);
    logic [4:0] prev;
    logic [4:0] oh;
    int         k;
    int         n_l;
    bit         seen;
    bus.enable_mask_i = mask;
    bus.timeout_i     = 8'd0;
    bus.start_i       = 1'b1;
    step();
    bus.start_i = 1'b0;
    prev = '0;
    k    = 0;
    n_l  = 0;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      bus.child_done_i = prev;
      if (bus.child_start_o != '0) begin
        while (k < 5 && !mask[k]) k++;
        oh = 5'b00001 << k;
        chk({tag, "_launch_order"}, 32'(bus.child_start_o), 32'(oh));
        k++;
        n_l++;
      end
      prev = bus.child_start_o;
      if (bus.done_o) begin
        seen = 1'b1;
        chk({tag, "_error"}, 32'(bus.error_o), 32'd0);
      end
      step();
    end
    bus.child_done_i = '0;
    chk({tag, "_launch_count"}, 32'(n_l), 32'($countones(mask)));
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [4:0] acc;
    logic [4:0] prev;
    int         active;
    int         age;
    int         n_l;
    int         bad;
    bit         seen;
    bit         found;
    n_vec = 0;
    n_err = 0;
    rst               = 1'b1;
    bus.start_i       = 1'b0;
    bus.enable_mask_i = '0;
    bus.timeout_i     = '0;
    bus.child_done_i  = '0;
    step();
    step();

    // Reset state
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_child_start", 32'(bus.child_start_o), 32'd0);
    chk("rst_err_idx", 32'(bus.err_idx_o), 32'd0);
    chk("rst_cur_idx", 32'(bus.cur_idx_o), 32'd0);
    rst = 1'b0;
    step();

    // Single child, done in N+3; inputs changed after acceptance must not matter
    bus.enable_mask_i = 5'b00001;
    bus.timeout_i     = 8'd0;
    bus.start_i       = 1'b1;
    step();
    bus.start_i       = 1'b0;
    bus.enable_mask_i = 5'b11111;
    bus.timeout_i     = 8'd1;
    chk("one_n1_busy", 32'(bus.busy_o), 32'd1);
    chk("one_n1_start", 32'(bus.child_start_o), 32'd0);
    step();
    chk("one_n2_start", 32'(bus.child_start_o), 32'h01);
    step();
    bus.child_done_i = 5'b00001;
    chk("one_n3_start", 32'(bus.child_start_o), 32'd0);
    step();
    bus.child_done_i = 5'b00000;
    chk("one_n4_cur_idx", 32'(bus.cur_idx_o), 32'd1);
    step();
    step();
    step();
    chk("one_n7_done", 32'(bus.done_o), 32'd0);
    chk("one_n7_cur_idx", 32'(bus.cur_idx_o), 32'd4);
    step();
    chk("one_n8_done", 32'(bus.done_o), 32'd1);
    chk("one_n8_error", 32'(bus.error_o), 32'd0);
    chk("one_n8_busy", 32'(bus.busy_o), 32'd1);
    step();
    chk("one_n9_busy", 32'(bus.busy_o), 32'd0);
    chk("one_n9_done", 32'(bus.done_o), 32'd0);

    // Timeout 3 on child 0
    bus.enable_mask_i = 5'b00001;
    bus.timeout_i     = 8'd3;
    bus.start_i       = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("tmo3_n6_done", 32'(bus.done_o), 32'd0);
    step();
    chk("tmo3_n7_done", 32'(bus.done_o), 32'd1);
    chk("tmo3_n7_error", 32'(bus.error_o), 32'd1);
    chk("tmo3_n7_err_idx", 32'(bus.err_idx_o), 32'd0);
    step();
    chk("tmo3_n8_error", 32'(bus.error_o), 32'd0);
    chk("tmo3_n8_busy", 32'(bus.busy_o), 32'd0);

    // Timeout 1 on child 2: err_idx must show 2 and hold
    bus.enable_mask_i = 5'b00100;
    bus.timeout_i     = 8'd1;
    bus.start_i       = 1'b1;
    step();
    bus.start_i = 1'b0;
    step();
    step();
    step();
    chk("tmo1_n4_start", 32'(bus.child_start_o), 32'h04);
    step();
    step();
    step();
    chk("tmo1_n7_done", 32'(bus.done_o), 32'd1);
    chk("tmo1_n7_error", 32'(bus.error_o), 32'd1);
    chk("tmo1_n7_err_idx", 32'(bus.err_idx_o), 32'd2);
    step();
    step();
    step();
    chk("tmo1_hold_err_idx", 32'(bus.err_idx_o), 32'd2);

    // Empty mask: pure scan, done 6 cycles after start, err_idx cleared on accept
    bus.enable_mask_i = 5'b00000;
    bus.timeout_i     = 8'd0;
    bus.start_i       = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("empty_n1_err_idx", 32'(bus.err_idx_o), 32'd0);
    acc = bus.child_start_o;
    for (int i = 0; i < 4; i++) begin
      step();
      acc = acc | bus.child_start_o;
    end
    chk("empty_n5_done", 32'(bus.done_o), 32'd0);
    step();
    acc = acc | bus.child_start_o;
    chk("empty_n6_done", 32'(bus.done_o), 32'd1);
    chk("empty_n6_error", 32'(bus.error_o), 32'd0);
    chk("empty_no_launch", 32'(acc), 32'd0);
    step();

    // Done and timeout on the same cycle: done wins
    bus.enable_mask_i = 5'b00001;
    bus.timeout_i     = 8'd2;
    bus.start_i       = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    bus.child_done_i = 5'b00001;
    step();
    bus.child_done_i = 5'b00000;
    chk("prio_n6_cur_idx", 32'(bus.cur_idx_o), 32'd1);
    chk("prio_n6_done", 32'(bus.done_o), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("prio_n10_done", 32'(bus.done_o), 32'd1);
    chk("prio_n10_error", 32'(bus.error_o), 32'd0);
    step();

    // Full sequence over all five children
    run_respond("full", 5'b11111);
    run_respond("sparse", 5'b10110);

    // Start held high with stray done bits on inactive children
    bus.enable_mask_i = 5'b00011;
    bus.timeout_i     = 8'd0;
    bus.start_i       = 1'b1;
    step();
    active = -1;
    age    = 0;
    n_l    = 0;
    bad    = 0;
    seen   = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      if (bus.child_start_o != '0) begin
        if (active != -1) bad++;
        active = (bus.child_start_o == 5'b00010) ? 1 : 0;
        age    = 0;
        n_l++;
      end
      if (active >= 0) begin
        prev = 5'b00001 << active;
        if (age < 4) begin
          bus.child_done_i = ~prev;
        end else begin
          bus.child_done_i = prev;
          active = -1;
        end
        age++;
      end else begin
        bus.child_done_i = 5'b00000;
      end
      if (bus.done_o) seen = 1'b1;
      step();
    end
    bus.child_done_i = 5'b00000;
    chk("stray_launch_count", 32'(n_l), 32'd2);
    chk("stray_early_advance", 32'(bad), 32'd0);
    chk("stray_done_seen", 32'(seen), 32'd1);
    chk("held_start_idle_gap", 32'(bus.busy_o), 32'd0);
    step();
    chk("held_start_rerun", 32'(bus.busy_o), 32'd1);
    bus.start_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Reset while waiting on child 2
    bus.enable_mask_i = 5'b11111;
    bus.timeout_i     = 8'd0;
    bus.start_i       = 1'b1;
    step();
    bus.start_i = 1'b0;
    prev  = '0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      bus.child_done_i = prev;
      if (bus.child_start_o == 5'b00100) found = 1'b1;
      else begin
        prev = bus.child_start_o;
        step();
      end
    end
    bus.child_done_i = 5'b00000;
    chk("rstmid_reached_child2", 32'(found), 32'd1);
    step();
    chk("rstmid_wait_idx", 32'(bus.cur_idx_o), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_busy", 32'(bus.busy_o), 32'd0);
    chk("rstmid_cur_idx", 32'(bus.cur_idx_o), 32'd0);
    chk("rstmid_done", 32'(bus.done_o), 32'd0);
    chk("rstmid_error", 32'(bus.error_o), 32'd0);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      acc = acc | bus.child_start_o | {4'd0, bus.done_o};
    end
    chk("rstmid_quiet", 32'(acc), 32'd0);
    run_respond("after_rst", 5'b11111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
